// File: rtl/prestep_pkg.sv
// Shared types and sizing helpers for the banked coefficient loader.
package prestep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } prestep_state_t;

  localparam int DEF_BITS  = 32;
  localparam int DEF_CGES  = 49;
  localparam int DEF_NBANK = 2;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prestep_ext_lane.sv
// One output lane: optional tap gate, sign/zero extension to MAX bits, output register.
module prestep_ext_lane #(
  parameter int BITS = 8,
  parameter int MAX  = 11,
  parameter int SEXT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [BITS-1:0] data,
  output logic [MAX-1:0]  q
);

  logic [BITS-1:0] gated;
  logic [MAX-1:0]  ext_val;

  assign gated = en ? data : '0;

  generate
    if (MAX > BITS) begin : g_widen
      logic fill_bit;
      assign fill_bit = (SEXT != 0) ? gated[BITS-1] : 1'b0;
      assign ext_val  = {{(MAX-BITS){fill_bit}}, gated};
    end else begin : g_same
      assign ext_val = gated;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= ext_val;
  end

endmodule

// File: rtl/prestep_bank_loader.sv
// Multi-banked coefficient front end: streams a shadow bank, swaps on commit,
// and presents masked, extended, registered lanes of the active bank.
module prestep_bank_loader
  import prestep_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int CGES  = DEF_CGES,
  parameter int NBANK = DEF_NBANK,
  parameter int SEXT  = 1,
  parameter int MAX   = $clog2(CGES) + BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ld_start,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [BITS-1:0]           ld_data,
  input  logic                      ld_abort,
  input  logic                      commit,
  output logic                      commit_err,
  output logic                      full,
  input  logic                      mask_wen,
  input  logic [CGES-1:1]           cges,
  output logic                      swap_done,
  output logic                      coeff_valid,
  output logic [CGES-1:0][MAX-1:0]  coeff
);

  localparam int IDX_W = idx_width(CGES);
  localparam int SEL_W = idx_width(NBANK);

  prestep_state_t   state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [SEL_W-1:0] act_sel_reg, load_sel;
  logic [CGES-1:1]  mask_reg;
  logic             wr_en, commit_acc, commit_err_next;
  logic             swap_pend_reg, swap_done_reg, coeff_valid_reg, commit_err_reg;
  logic [BITS-1:0]  bank [NBANK][CGES];

  function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(NBANK-1)) ? '0 : s + SEL_W'(1);
  endfunction

  assign load_sel = sel_inc(act_sel_reg);

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    wr_en           = 1'b0;
    commit_acc      = 1'b0;
    commit_err_next = commit && (state_reg != FULL);
    ld_ready        = (state_reg == LOAD);
    full            = (state_reg == FULL);
    case (state_reg)
      IDLE: begin
        if (ld_start) begin
          state_next = LOAD;
          idx_next   = '0;
        end
      end
      LOAD: begin
        // Abort outranks a word arriving in the same cycle.
        if (ld_abort) begin
          state_next = IDLE;
          idx_next   = '0;
        end else if (ld_valid) begin
          wr_en = 1'b1;
          if (idx_reg == IDX_W'(CGES-1)) begin
            state_next = FULL;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (ld_abort) begin
          state_next = IDLE;
          idx_next   = '0;
        end else if (commit) begin
          state_next = IDLE;
          commit_acc = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      act_sel_reg     <= '0;
      mask_reg        <= '0;
      swap_pend_reg   <= 1'b0;
      swap_done_reg   <= 1'b0;
      coeff_valid_reg <= 1'b0;
      commit_err_reg  <= 1'b0;
      for (int b = 0; b < NBANK; b++)
        for (int t = 0; t < CGES; t++)
          bank[b][t] <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      commit_err_reg <= commit_err_next;
      swap_pend_reg  <= commit_acc;
      // Lanes sample the new bank one edge after act_sel moves, so the pulse lags by one.
      swap_done_reg  <= swap_pend_reg;
      if (swap_pend_reg) coeff_valid_reg <= 1'b1;
      if (commit_acc)    act_sel_reg     <= load_sel;
      if (mask_wen)      mask_reg        <= cges;
      if (wr_en)         bank[load_sel][idx_reg] <= ld_data;
    end
  end

  assign commit_err  = commit_err_reg;
  assign swap_done   = swap_done_reg;
  assign coeff_valid = coeff_valid_reg;

  generate
    for (genvar gi = 0; gi < CGES; gi++) begin : g_lane
      logic lane_en;
      if (gi == 0) begin : g_tap0
        assign lane_en = 1'b1;
      end else begin : g_tapn
        assign lane_en = mask_reg[gi];
      end
      prestep_ext_lane #(
        .BITS (BITS),
        .MAX  (MAX),
        .SEXT (SEXT)
      ) u_lane (
        .clk   (clk),
        .reset (reset),
        .en    (lane_en),
        .data  (bank[act_sel_reg][gi]),
        .q     (coeff[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_prestep_bank_loader.sv
// Directed bench for prestep_bank_loader (BITS=8, CGES=5, NBANK=2, MAX=11), with a zero-extend twin.
module tb_prestep_bank_loader;

  localparam int BITS = 8;
  localparam int CGES = 5;
  localparam int MAX  = 11;

  logic clk = 1'b0;
  logic reset, ld_start, ld_valid, ld_abort, commit, mask_wen;
  logic [BITS-1:0] ld_data;
  logic [CGES-1:1] cges;
  logic ld_ready, commit_err, full, swap_done, coeff_valid;
  logic ld_ready_z, commit_err_z, full_z, swap_done_z, coeff_valid_z;
  logic [CGES-1:0][MAX-1:0] coeff, coeff_z;

  int checks = 0;
  int fails  = 0;
  logic [MAX-1:0] exp_c [CGES];

  always #5 clk = ~clk;

  prestep_bank_loader #(.BITS(BITS), .CGES(CGES), .NBANK(2), .SEXT(1), .MAX(MAX)) dut (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_abort(ld_abort), .commit(commit), .commit_err(commit_err),
    .full(full), .mask_wen(mask_wen), .cges(cges), .swap_done(swap_done),
    .coeff_valid(coeff_valid), .coeff(coeff)
  );

  prestep_bank_loader #(.BITS(BITS), .CGES(CGES), .NBANK(2), .SEXT(0), .MAX(MAX)) dut_z (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready_z),
    .ld_data(ld_data), .ld_abort(ld_abort), .commit(commit), .commit_err(commit_err_z),
    .full(full_z), .mask_wen(mask_wen), .cges(cges), .swap_done(swap_done_z),
    .coeff_valid(coeff_valid_z), .coeff(coeff_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [BITS-1:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ld_start = 0; ld_valid = 0; ld_abort = 0; commit = 0; mask_wen = 0;
    ld_data = '0; cges = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < CGES; i++) begin
      checks++;
      if (coeff[i] !== 11'h000) begin
        $display("FAIL reset_coeff lane %0d got %h want 000", i, coeff[i]); fails++;
      end
    end
    checks++;
    if ({ld_ready, full, coeff_valid, swap_done, commit_err} !== 5'b0) begin
      $display("FAIL reset_flags got %b want 00000", {ld_ready, full, coeff_valid, swap_done, commit_err});
      fails++;
    end
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    checks++;
    if (ld_ready !== 1'b1) begin
      $display("FAIL start_ready got %b want 1", ld_ready); fails++;
    end
    $display("test_reset done");
  endtask

  task automatic test_first_commit();
    logic [BITS-1:0] words [CGES] = '{8'h80, 8'h01, 8'h7F, 8'hFF, 8'h10};
    for (int i = 0; i < CGES; i++) push(words[i]);
    checks++;
    if (full !== 1'b1 || ld_ready !== 1'b0) begin
      $display("FAIL full_flag got full=%b ready=%b want 1/0", full, ld_ready); fails++;
    end
    mask_wen = 1'b1; cges = 4'b1111; tick(); mask_wen = 1'b0;
    commit = 1'b1; tick(); commit = 1'b0;
    checks++;
    if (coeff[0] !== 11'h000 || swap_done !== 1'b0) begin
      $display("FAIL commit_latency got lane0=%h swap=%b want 000/0", coeff[0], swap_done); fails++;
    end
    tick();
    exp_c = '{11'h780, 11'h001, 11'h07F, 11'h7FF, 11'h010};
    for (int i = 0; i < CGES; i++) begin
      checks++;
      if (coeff[i] !== exp_c[i]) begin
        $display("FAIL commit1_coeff lane %0d got %h want %h", i, coeff[i], exp_c[i]); fails++;
      end
    end
    checks++;
    if (swap_done !== 1'b1 || coeff_valid !== 1'b1 || full !== 1'b0) begin
      $display("FAIL commit1_flags got swap=%b valid=%b full=%b want 1/1/0", swap_done, coeff_valid, full);
      fails++;
    end
    tick();
    checks++;
    if (swap_done !== 1'b0) begin
      $display("FAIL swap_once got %b want 0", swap_done); fails++;
    end
    $display("test_first_commit done");
  endtask

  task automatic test_zero_ext();
    checks++;
    if (coeff_z[0] !== 11'h080 || coeff_z[3] !== 11'h0FF) begin
      $display("FAIL zext_coeff got lane0=%h lane3=%h want 080/0FF", coeff_z[0], coeff_z[3]); fails++;
    end
    $display("test_zero_ext done");
  endtask

  task automatic test_mask();
    mask_wen = 1'b1; cges = 4'b0101; tick(); mask_wen = 1'b0;
    tick();
    exp_c = '{11'h780, 11'h001, 11'h000, 11'h7FF, 11'h000};
    for (int i = 0; i < CGES; i++) begin
      checks++;
      if (coeff[i] !== exp_c[i]) begin
        $display("FAIL mask_coeff lane %0d got %h want %h", i, coeff[i], exp_c[i]); fails++;
      end
    end
    $display("test_mask done");
  endtask

  task automatic test_gapped_load();
    logic [BITS-1:0] words [CGES] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i < CGES; i++) begin
      push(words[i]);
      tick();
      checks++;
      if (coeff[0] !== 11'h780 || coeff[3] !== 11'h7FF) begin
        $display("FAIL load_quiet word %0d got lane0=%h lane3=%h want 780/7FF", i, coeff[0], coeff[3]);
        fails++;
      end
    end
    checks++;
    if (full !== 1'b1) begin
      $display("FAIL gapped_full got %b want 1", full); fails++;
    end
    commit = 1'b1; mask_wen = 1'b1; cges = 4'b1111; tick();
    commit = 1'b0; mask_wen = 1'b0;
    tick();
    exp_c = '{11'h011, 11'h022, 11'h033, 11'h044, 11'h055};
    for (int i = 0; i < CGES; i++) begin
      checks++;
      if (coeff[i] !== exp_c[i]) begin
        $display("FAIL commit2_coeff lane %0d got %h want %h", i, coeff[i], exp_c[i]); fails++;
      end
    end
    checks++;
    if (swap_done !== 1'b1) begin
      $display("FAIL commit2_swap got %b want 1", swap_done); fails++;
    end
    $display("test_gapped_load done");
  endtask

  task automatic test_err_abort();
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    push(8'hA1); push(8'hA2);
    commit = 1'b1; tick(); commit = 1'b0;
    checks++;
    if (commit_err !== 1'b1 || ld_ready !== 1'b1) begin
      $display("FAIL commit_in_load got err=%b ready=%b want 1/1", commit_err, ld_ready); fails++;
    end
    tick();
    checks++;
    if (commit_err !== 1'b0 || swap_done !== 1'b0) begin
      $display("FAIL err_pulse got err=%b swap=%b want 0/0", commit_err, swap_done); fails++;
    end
    push(8'hA3); push(8'hA4); push(8'hA5);
    checks++;
    if (full !== 1'b1) begin
      $display("FAIL abort_prefull got %b want 1", full); fails++;
    end
    ld_abort = 1'b1; commit = 1'b1; tick(); ld_abort = 1'b0; commit = 1'b0;
    checks++;
    if (full !== 1'b0 || ld_ready !== 1'b0 || commit_err !== 1'b0) begin
      $display("FAIL abort_state got full=%b ready=%b err=%b want 0/0/0", full, ld_ready, commit_err);
      fails++;
    end
    tick();
    checks++;
    if (swap_done !== 1'b0 || coeff[0] !== 11'h011 || coeff[4] !== 11'h055) begin
      $display("FAIL abort_keep got swap=%b lane0=%h lane4=%h want 0/011/055", swap_done, coeff[0], coeff[4]);
      fails++;
    end
    $display("test_err_abort done");
  endtask

  task automatic test_reset_midload();
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    push(8'hC1); push(8'hC2);
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    for (int i = 0; i < CGES; i++) begin
      checks++;
      if (coeff[i] !== 11'h000) begin
        $display("FAIL rst_mid_coeff lane %0d got %h want 000", i, coeff[i]); fails++;
      end
    end
    checks++;
    if ({ld_ready, full, coeff_valid} !== 3'b000) begin
      $display("FAIL rst_mid_flags got %b want 000", {ld_ready, full, coeff_valid}); fails++;
    end
    $display("test_reset_midload done");
  endtask

  initial begin
    test_reset();
    test_first_commit();
    test_zero_ext();
    test_mask();
    test_gapped_load();
    test_err_abort();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
